// File: rtl/lpbk_src_ctrl.sv
// lpbk_src_ctrl: loopback/BIST source-select FSM for the CLK219 encoder datapath.
// Optional statistics counters are built when LPBK_SRC_CTRL_STATS_EN is defined.
module lpbk_src_ctrl #(
    parameter int SYNC_HOLD   = 64,
    parameter int LOS_HOLD    = 16,
    parameter int ARM_TIMEOUT = 4096,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lpbk_req,
    input  logic             rx_sync,
    input  logic             bist_val,
    input  logic [1:0]       bist_sh,
    input  logic [7:0]       bist_ctl_type,
    output logic             lpbk_en,
    output logic             bist_pause,
    output logic             los_flag,
    output logic             arm_timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] sw_cnt,
    output logic [CNT_W-1:0] los_cnt
);
    localparam int TW = $clog2(ARM_TIMEOUT);
    localparam int SW = $clog2(SYNC_HOLD + 1);
    localparam int LW = $clog2(LOS_HOLD + 1);
    localparam logic [TW-1:0] TMAX = TW'(ARM_TIMEOUT - 1);
    localparam logic [SW-1:0] SMAX = SW'(SYNC_HOLD);
    localparam logic [LW-1:0] LMAX = LW'(LOS_HOLD);

    typedef enum logic [2:0] {
        S_BIST   = 3'd0,
        S_ARM    = 3'd1,
        S_SWITCH = 3'd2,
        S_LPBK   = 3'd3,
        S_LOS    = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] sync_cnt_q, sync_cnt_d;
    logic [LW-1:0] los_cnt_i_q, los_cnt_i_d;
    logic          sw_seen_q, sw_seen_d;
    logic          lpbk_en_q, lpbk_en_d;
    logic          bist_pause_q, bist_pause_d;
    logic          los_flag_q, los_flag_d;
    logic          arm_timeout_q, arm_timeout_d;
    logic          idle_blk, sync_ok, los_hit, tmo;

    // Idle-boundary detect plus saturating run lengths of rx_sync high and low
    always_comb begin
        idle_blk    = bist_val && bist_sh == 2'b01 && bist_ctl_type == 8'h1E;
        sync_ok     = sync_cnt_q == SMAX;
        los_hit     = los_cnt_i_q == LMAX;
        tmo         = timer_q == TMAX;
        sync_cnt_d  = !rx_sync ? '0 : sync_ok ? sync_cnt_q : sync_cnt_q + SW'(1);
        los_cnt_i_d = rx_sync ? '0 : los_hit ? los_cnt_i_q : los_cnt_i_q + LW'(1);
    end

    // Next state; outputs are decoded from the next state so they register with it
    always_comb begin
        state_d       = state_q;
        timer_d       = state_q == S_ARM ? timer_q + TW'(1) : '0;
        sw_seen_d     = state_q == S_SWITCH;
        arm_timeout_d = 1'b0;
        case (state_q)
            S_BIST:   state_d = lpbk_req ? S_ARM : S_BIST;
            S_ARM: begin
                if (!lpbk_req) state_d = S_BIST;
                else if (sync_ok) state_d = S_SWITCH;
                else if (tmo) begin
                    state_d       = S_BIST;
                    arm_timeout_d = 1'b1;
                end
            end
            S_SWITCH: state_d = !lpbk_req ? S_BIST : !rx_sync ? S_ARM :
                                (sw_seen_q && idle_blk) ? S_LPBK : S_SWITCH;
            S_LPBK:   state_d = !lpbk_req ? S_BIST : los_hit ? S_LOS : S_LPBK;
            S_LOS:    state_d = !lpbk_req ? S_BIST : sync_ok ? S_LPBK : S_LOS;
            default:  state_d = S_BIST;
        endcase
        lpbk_en_d    = state_d == S_LPBK || state_d == S_LOS;
        bist_pause_d = lpbk_en_d || state_d == S_SWITCH;
        los_flag_d   = state_d == S_LOS;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_BIST;
            timer_q       <= '0;
            sync_cnt_q    <= '0;
            los_cnt_i_q   <= '0;
            sw_seen_q     <= 1'b0;
            lpbk_en_q     <= 1'b0;
            bist_pause_q  <= 1'b0;
            los_flag_q    <= 1'b0;
            arm_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            sync_cnt_q    <= sync_cnt_d;
            los_cnt_i_q   <= los_cnt_i_d;
            sw_seen_q     <= sw_seen_d;
            lpbk_en_q     <= lpbk_en_d;
            bist_pause_q  <= bist_pause_d;
            los_flag_q    <= los_flag_d;
            arm_timeout_q <= arm_timeout_d;
        end
    end

    assign state       = state_q;
    assign lpbk_en     = lpbk_en_q;
    assign bist_pause  = bist_pause_q;
    assign los_flag    = los_flag_q;
    assign arm_timeout = arm_timeout_q;

`ifdef LPBK_SRC_CTRL_STATS_EN
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d, los_cnt_q, los_cnt_d;

    // Saturating counts of loopback entries and loss-of-lock entries
    always_comb begin
        sw_cnt_d  = sw_cnt_q + CNT_W'(state_q == S_SWITCH && state_d == S_LPBK && !(&sw_cnt_q));
        los_cnt_d = los_cnt_q + CNT_W'(state_q == S_LPBK && state_d == S_LOS && !(&los_cnt_q));
    end

    // Statistics clear only on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_cnt_q  <= '0;
            los_cnt_q <= '0;
        end else begin
            sw_cnt_q  <= sw_cnt_d;
            los_cnt_q <= los_cnt_d;
        end
    end

    assign sw_cnt  = sw_cnt_q;
    assign los_cnt = los_cnt_q;
`else
    assign sw_cnt  = '0;
    assign los_cnt = '0;
`endif
endmodule

// File: tb/tb_lpbk_src_ctrl.sv
// tb_lpbk_src_ctrl: scenario tasks push expected output vectors per cycle; observed
// outputs are logged on the falling edge and compared when each scenario completes.
module tb_lpbk_src_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, lpbk_req = 1'b0, rx_sync = 1'b0, bist_val = 1'b0;
    logic [1:0] bist_sh = 2'b00;
    logic [7:0] bist_ctl_type = 8'h00;
    logic       lpbk_en, bist_pause, los_flag, arm_timeout;
    logic [2:0] state;
    logic [1:0] sw_cnt, los_cnt;

    int cyc = 0, n_vec = 0, n_err = 0, idle_mode = 0;
    logic [6:0] obs [0:32767];

    typedef struct {
        int         c;
        logic [6:0] v;
        string      tag;
    } exp_t;
    exp_t sb [$];

    // {arm_timeout, los_flag, bist_pause, lpbk_en, state[2:0]}
    localparam logic [6:0] E_BIST   = 7'b0000000;
    localparam logic [6:0] E_ARM    = 7'b0000001;
    localparam logic [6:0] E_SWITCH = 7'b0010010;
    localparam logic [6:0] E_LPBK   = 7'b0011011;
    localparam logic [6:0] E_LOS    = 7'b0111100;
    localparam logic [6:0] E_TMO    = 7'b1000000;

    lpbk_src_ctrl #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .lpbk_req(lpbk_req), .rx_sync(rx_sync),
        .bist_val(bist_val), .bist_sh(bist_sh), .bist_ctl_type(bist_ctl_type),
        .lpbk_en(lpbk_en), .bist_pause(bist_pause), .los_flag(los_flag),
        .arm_timeout(arm_timeout), .state(state), .sw_cnt(sw_cnt), .los_cnt(los_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 32768) obs[cyc] <= {arm_timeout, los_flag, bist_pause, lpbk_en, state};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge and set up the BIST block for the following edge
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            bist_val = 1'b1;
            if (idle_mode != 0 && (cyc + 1) % idle_mode == 0) begin
                bist_sh = 2'b01; bist_ctl_type = 8'h1E;
            end else if ($urandom_range(0, 1) == 1) begin
                bist_sh = 2'b01; bist_ctl_type = 8'h2D;
            end else begin
                bist_sh = 2'b10; bist_ctl_type = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic expect_at(input int c, input logic [6:0] v, input string tag);
        sb.push_back('{c, v, tag});
    endtask

    task automatic enter_lpbk();
        int n = 0;
        lpbk_req = 1'b1; rx_sync = 1'b1; idle_mode = 1;
        while (state !== 3'd3 && n < 300) begin step(1); n++; end
        n_vec++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL enter_lpbk: state %0d after %0d cycles, want 3", state, n);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; lpbk_req = 1'b1; rx_sync = 1'b1; idle_mode = 1;
        step(3);
        expect_at(cyc - 1, E_BIST, "reset_hold_a");
        expect_at(cyc, E_BIST, "reset_hold_b");
        rst_n = 1'b1; lpbk_req = 1'b0; rx_sync = 1'b0;
        step(1);
        expect_at(cyc, E_BIST, "reset_release");
        n_vec++;
        if (sw_cnt !== 2'd0 || los_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL reset_stats: sw_cnt=%0d los_cnt=%0d, want 0 0", sw_cnt, los_cnt);
        end
        step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs[e.c] !== e.v) begin n_err++; $display("FAIL %s @cyc %0d: got %b want %b", e.tag, e.c, obs[e.c], e.v); end
        end
    endtask

    task automatic test_enter();
        exp_t e;
        int c0;
        lpbk_req = 1'b0; rx_sync = 1'b0; idle_mode = 4;
        while ((cyc + 66) % 4 != 0) step(1);
        c0 = cyc; lpbk_req = 1'b1; rx_sync = 1'b1;
        step(75);
        expect_at(c0 + 1,  E_ARM,    "arm_entry");
        expect_at(c0 + 64, E_ARM,    "arm_before_sync_ok");
        expect_at(c0 + 65, E_SWITCH, "switch_on_sync_ok");
        expect_at(c0 + 66, E_SWITCH, "idle_ignored_1st_switch");
        expect_at(c0 + 69, E_SWITCH, "switch_wait_idle");
        expect_at(c0 + 70, E_LPBK,   "lpbk_on_idle");
        expect_at(c0 + 75, E_LPBK,   "lpbk_hold");
        step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs[e.c] !== e.v) begin n_err++; $display("FAIL %s @cyc %0d: got %b want %b", e.tag, e.c, obs[e.c], e.v); end
        end
    endtask

    task automatic test_los();
        exp_t e;
        int c;
        c = cyc; rx_sync = 1'b0; step(15); rx_sync = 1'b1; step(5);
        expect_at(c + 15, E_LPBK, "low15_in_lpbk");
        expect_at(c + 20, E_LPBK, "low15_stays_lpbk");
        c = cyc; rx_sync = 1'b0; step(16); rx_sync = 1'b1; step(1);
        expect_at(c + 16, E_LPBK, "low16_pre_los");
        expect_at(c + 17, E_LOS,  "los_entry");
        step(63);
        expect_at(c + 80, E_LOS,  "los_before_sync_ok");
        step(1);
        expect_at(c + 81, E_LPBK, "los_recover");
        step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs[e.c] !== e.v) begin n_err++; $display("FAIL %s @cyc %0d: got %b want %b", e.tag, e.c, obs[e.c], e.v); end
        end
    endtask

    task automatic test_drop();
        exp_t e;
        int c;
        c = cyc; lpbk_req = 1'b0; step(1);
        expect_at(c,     E_LPBK, "drop_lpbk_pre");
        expect_at(c + 1, E_BIST, "drop_from_lpbk");
        enter_lpbk();
        c = cyc; rx_sync = 1'b0; step(17);
        expect_at(c + 17, E_LOS, "drop_los_entry");
        rx_sync = 1'b1; step(64);
        expect_at(c + 81, E_LOS, "drop_los_pre");
        lpbk_req = 1'b0; step(1);
        expect_at(c + 82, E_BIST, "drop_from_los_beats_sync_ok");
        lpbk_req = 1'b0; rx_sync = 1'b1; idle_mode = 0; step(70);
        c = cyc; lpbk_req = 1'b1; step(3);
        rx_sync = 1'b0; step(1);
        rx_sync = 1'b1; step(67);
        lpbk_req = 1'b0; step(1);
        expect_at(c + 1,  E_ARM,    "sw_arm");
        expect_at(c + 2,  E_SWITCH, "sw_switch_saturated_sync");
        expect_at(c + 3,  E_SWITCH, "sw_no_idle_hold");
        expect_at(c + 4,  E_ARM,    "sw_sync_loss_to_arm");
        expect_at(c + 68, E_ARM,    "sw_rearm_wait");
        expect_at(c + 69, E_SWITCH, "sw_reswitch");
        expect_at(c + 71, E_SWITCH, "drop_switch_pre");
        expect_at(c + 72, E_BIST,   "drop_from_switch");
        step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs[e.c] !== e.v) begin n_err++; $display("FAIL %s @cyc %0d: got %b want %b", e.tag, e.c, obs[e.c], e.v); end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int c, cs, pulses, en_seen;
        lpbk_req = 1'b0; rx_sync = 1'b0; idle_mode = 1; step(2);
        c = cyc; cs = c; lpbk_req = 1'b1; step(4096);
        expect_at(c + 1,    E_ARM,  "tmo_arm_entry");
        expect_at(c + 4096, E_ARM,  "tmo_last_arm");
        step(1);
        expect_at(c + 4097, E_TMO,  "tmo_pulse");
        lpbk_req = 1'b0; step(1);
        expect_at(c + 4098, E_BIST, "tmo_pulse_ends");
        c = cyc; lpbk_req = 1'b1;
        for (int i = 0; i < 4097; i++) begin rx_sync = ((i / 63) % 2) == 0; step(1); end
        expect_at(c + 4096, E_ARM,  "tmo_toggle_last_arm");
        expect_at(c + 4097, E_TMO,  "tmo_toggle_pulse");
        lpbk_req = 1'b0; rx_sync = 1'b0; step(1);
        expect_at(c + 4098, E_BIST, "tmo_toggle_ends");
        pulses = 0; en_seen = 0;
        step(1);
        for (int k = cs + 1; k <= c + 4098; k++) begin pulses += int'(obs[k][6]); en_seen += int'(obs[k][3]); end
        n_vec++;
        if (pulses != 2 || en_seen != 0) begin
            n_err++;
            $display("FAIL tmo_window: %0d pulses, %0d lpbk_en cycles; want 2 and 0", pulses, en_seen);
        end
        c = cyc; lpbk_req = 1'b1;
        for (int i = 0; i < 4097; i++) begin rx_sync = i >= 4032; step(1); end
        expect_at(c + 4096, E_ARM,    "tie_last_arm");
        expect_at(c + 4097, E_SWITCH, "tie_sync_ok_wins");
        lpbk_req = 1'b0; step(1);
        expect_at(c + 4098, E_BIST,   "tie_drop");
        step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs[e.c] !== e.v) begin n_err++; $display("FAIL %s @cyc %0d: got %b want %b", e.tag, e.c, obs[e.c], e.v); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int c;
        enter_lpbk();
        c = cyc; rst_n = 1'b0; step(1); rst_n = 1'b1;
        n_vec++;
        if (sw_cnt !== 2'd0 || los_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid_stats: sw_cnt=%0d los_cnt=%0d, want 0 0", sw_cnt, los_cnt);
        end
        step(2);
        expect_at(c,     E_LPBK, "reset_mid_pre");
        expect_at(c + 1, E_BIST, "reset_mid_clears");
        expect_at(c + 2, E_ARM,  "reset_mid_rearm");
        expect_at(c + 3, E_ARM,  "reset_mid_sync_restart");
        step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_vec++;
            if (obs[e.c] !== e.v) begin n_err++; $display("FAIL %s @cyc %0d: got %b want %b", e.tag, e.c, obs[e.c], e.v); end
        end
    endtask

    task automatic test_stats();
        logic [1:0] exp_sw, exp_los;
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enter_lpbk();
            if (i < 2) begin rx_sync = 1'b0; step(17); rx_sync = 1'b1; step(66); end
            lpbk_req = 1'b0; step(2);
        end
`ifdef LPBK_SRC_CTRL_STATS_EN
        exp_sw = 2'd3; exp_los = 2'd2;
`else
        exp_sw = 2'd0; exp_los = 2'd0;
`endif
        n_vec++;
        if (sw_cnt !== exp_sw || los_cnt !== exp_los) begin
            n_err++;
            $display("FAIL stats_3_2: sw_cnt=%0d los_cnt=%0d, want %0d %0d", sw_cnt, los_cnt, exp_sw, exp_los);
        end
        for (int i = 0; i < 2; i++) begin enter_lpbk(); lpbk_req = 1'b0; step(2); end
        n_vec++;
        if (sw_cnt !== exp_sw || los_cnt !== exp_los) begin
            n_err++;
            $display("FAIL stats_saturate: sw_cnt=%0d los_cnt=%0d, want %0d %0d", sw_cnt, los_cnt, exp_sw, exp_los);
        end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_los();
        test_drop();
        test_timeout();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
